// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets, id width, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package irq_ctrl_pkg;

  // Source id is index+1, so 6 bits covers up to 32 sources with 0 meaning "none".
  localparam int ID_W = 6;

  // Word offsets, compared against mem_addr_i[4:2].
  localparam logic [2:0] REG_ENABLE  = 3'd0;
  localparam logic [2:0] REG_TRIG    = 3'd1;
  localparam logic [2:0] REG_PENDING = 3'd2;
  localparam logic [2:0] REG_CLAIM   = 3'd3;
  localparam logic [2:0] REG_STATUS  = 3'd4;

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } irqc_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins, reported as index+1.
// Latency: purely combinational.
// Backpressure: none.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC = 32
) (
  input  logic [NSRC-1:0] req,
  output logic            vld,
  output logic [ID_W-1:0] id
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    vld = 1'b0;
    id  = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        vld = 1'b1;
        id  = ID_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches/masks/prioritises sources, one irq to the core, claim/complete regs.
// Latency: raw level source -> irq_o in 2 cycles (+2 through a synchroniser); bus ready 1 cycle after valid.
// Backpressure: one bus request at a time; a new request is only accepted while mem_ready_o is low.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          NSRC       = 32,
  parameter logic [31:0] SYNC_MASK  = 32'h0002_0000,
  parameter logic [31:0] RST_ENABLE = 32'h0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NSRC-1:0] irq_src_i,
  input  logic            mem_valid_i,
  output logic            mem_ready_o,
  input  logic [31:0]     mem_addr_i,
  input  logic [31:0]     mem_wdata_i,
  input  logic [3:0]      mem_wstrb_i,
  output logic [31:0]     mem_rdata_o,
  output logic            irq_o,
  output logic [ID_W-1:0] irq_id_o
);

  localparam logic [NSRC-1:0] ONE = NSRC'(1);

  logic [NSRC-1:0] src_s, src_q, src_edge;
  logic [NSRC-1:0] enable_q, trig_q, pend_q, pend_nxt, trig_nxt;
  logic [NSRC-1:0] eligible, svc_mask, claim_clr, w1c_clr, trig_chg;
  logic [NSRC-1:0] wdat_n, bmask_n;
  logic [31:0]     bmask, rdat;
  logic [2:0]      sel;
  logic            acc, wr, rd, claim_go, complete_go, win_vld;
  logic [ID_W-1:0] win_id, svc_id_q;
  irqc_state_e     state_q;
  logic            unused_addr;

  // Source conditioning: optional 2-flop synchroniser per source.
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    if (SYNC_MASK[i]) begin : g_sync
      logic s1, s2;
      // Two-stage synchroniser for an asynchronous source.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          s1 <= 1'b0;
          s2 <= 1'b0;
        end else begin
          s1 <= irq_src_i[i];
          s2 <= s1;
        end
      end
      assign src_s[i] = s2;
    end else begin : g_raw
      assign src_s[i] = irq_src_i[i];
    end
  end

  assign src_edge = src_s & ~src_q;

  // Bus decode. Only address bits [4:2] select a register; everything else aliases.
  assign unused_addr = ^{mem_addr_i[31:5], mem_addr_i[1:0]};
  assign sel     = mem_addr_i[4:2];
  assign acc     = mem_valid_i && !mem_ready_o;
  assign wr      = acc && (|mem_wstrb_i);
  assign rd      = acc && !(|mem_wstrb_i);
  assign bmask   = {{8{mem_wstrb_i[3]}}, {8{mem_wstrb_i[2]}}, {8{mem_wstrb_i[1]}}, {8{mem_wstrb_i[0]}}};
  assign bmask_n = bmask[NSRC-1:0];
  assign wdat_n  = mem_wdata_i[NSRC-1:0];

  // The source currently in service is hidden from arbitration so it cannot re-fire.
  assign svc_mask = (state_q == SERVICE) ? (ONE << (svc_id_q - 1'b1)) : '0;
  assign eligible = pend_q & enable_q & ~svc_mask;

  irq_prio_enc #(.NSRC(NSRC)) u_prio (
    .req (eligible),
    .vld (win_vld),
    .id  (win_id)
  );

  assign claim_go    = rd && (sel == REG_CLAIM) && (state_q == IDLE) && win_vld;
  assign complete_go = wr && (sel == REG_CLAIM) && (state_q == SERVICE)
                       && (mem_wdata_i[ID_W-1:0] == svc_id_q);

  assign claim_clr = claim_go ? (ONE << (win_id - 1'b1)) : '0;
  assign w1c_clr   = (wr && (sel == REG_PENDING)) ? (wdat_n & bmask_n) : '0;
  assign trig_nxt  = (trig_q & ~bmask_n) | (wdat_n & bmask_n);
  assign trig_chg  = (wr && (sel == REG_TRIG)) ? (trig_nxt ^ trig_q) : '0;

  // Edge sources: a new edge beats any clear in the same cycle. Level sources track src_s.
  // A mode change drops whatever was pending under the old mode.
  assign pend_nxt = ((trig_q & ((pend_q & ~(claim_clr | w1c_clr)) | src_edge))
                    | (~trig_q & src_s)) & ~trig_chg;

  // Read mux, always from pre-update state.
  always_comb begin
    rdat = '0;
    case (sel)
      REG_ENABLE:  rdat = 32'(enable_q);
      REG_TRIG:    rdat = 32'(trig_q);
      REG_PENDING: rdat = 32'(pend_q);
      REG_CLAIM:   if (state_q == IDLE && win_vld) rdat = 32'(win_id);
      REG_STATUS: begin
        rdat[0]    = (state_q == SERVICE);
        rdat[13:8] = svc_id_q;
      end
      default:     rdat = '0;
    endcase
  end

  // Source history and pending bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_q  <= '0;
      pend_q <= '0;
    end else begin
      src_q  <= src_s;
      pend_q <= pend_nxt;
    end
  end

  // Byte-strobed configuration registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enable_q <= RST_ENABLE[NSRC-1:0];
      trig_q   <= '0;
    end else if (wr) begin
      if (sel == REG_ENABLE) enable_q <= (enable_q & ~bmask_n) | (wdat_n & bmask_n);
      if (sel == REG_TRIG)   trig_q   <= trig_nxt;
    end
  end

  // Claim/complete FSM with the bus handshake and registered irq outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      svc_id_q    <= '0;
      mem_ready_o <= 1'b0;
      mem_rdata_o <= '0;
      irq_o       <= 1'b0;
      irq_id_o    <= '0;
    end else begin
      mem_ready_o <= acc;
      mem_rdata_o <= rd ? rdat : '0;
      irq_o       <= (state_q == IDLE) && (|eligible);
      irq_id_o    <= win_vld ? win_id : '0;
      case (state_q)
        IDLE: begin
          if (claim_go) begin
            state_q  <= SERVICE;
            svc_id_q <= win_id;
          end
        end
        SERVICE: begin
          if (complete_go) begin
            state_q  <= IDLE;
            svc_id_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: reset, level/edge sources, claim/complete, W1C races, sync delay, reset abort.
// Latency: n/a.
// Backpressure: bus tasks wait a bounded number of cycles for mem_ready_o.
module tb_irq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] irq_src_i;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_wstrb_i;
  logic [31:0] mem_rdata_o;
  logic        irq_o;
  logic [5:0]  irq_id_o;

  int checks = 0;
  int errors = 0;

  irq_ctrl #(
    .NSRC       (32),
    .SYNC_MASK  (32'h0002_0000),
    .RST_ENABLE (32'h0000_0100)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .irq_src_i   (irq_src_i),
    .mem_valid_i (mem_valid_i),
    .mem_ready_o (mem_ready_o),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_wstrb_i (mem_wstrb_i),
    .mem_rdata_o (mem_rdata_o),
    .irq_o       (irq_o),
    .irq_id_o    (irq_id_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    rst_i       = 1'b1;
    irq_src_i   = '0;
    mem_valid_i = 1'b0;
    mem_addr_i  = '0;
    mem_wdata_i = '0;
    mem_wstrb_i = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // One bus transfer; returns at the negedge of the ready cycle.
  task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rdv);
    int n;
    mem_valid_i = 1'b1;
    mem_addr_i  = a;
    mem_wdata_i = d;
    mem_wstrb_i = s;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!mem_ready_o && n < 10);
    if (!mem_ready_o) begin
      checks++;
      errors++;
      $display("FAIL bus_timeout addr=%h got ready=0 want ready=1", a);
    end
    rdv = mem_rdata_o;
    mem_valid_i = 1'b0;
    mem_wstrb_i = '0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus_xfer(a, d, 4'hF, dummy);
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    bus_xfer(a, 32'h0, 4'h0, d);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL rst_irq got %b want 0", irq_o); end
    checks++; if (irq_id_o !== 6'd0) begin errors++; $display("FAIL rst_id got %0d want 0", irq_id_o); end
    checks++; if (mem_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", mem_ready_o); end
    checks++; if (mem_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", mem_rdata_o); end
    bus_rd(32'h00, d);
    checks++; if (d !== 32'h0000_0100) begin errors++; $display("FAIL rst_enable got %h want 00000100", d); end
    bus_rd(32'h10, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_status got %h want 0", d); end
  endtask

  task automatic test_level();
    logic [31:0] d;
    bus_wr(32'h00, 32'h8);
    bus_wr(32'h04, 32'h0);
    @(negedge clk_i);
    irq_src_i[3] = 1'b1;
    @(negedge clk_i);
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL lvl_n1 got %b want 0", irq_o); end
    @(negedge clk_i);
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL lvl_n2_irq got %b want 1", irq_o); end
    checks++; if (irq_id_o !== 6'd4) begin errors++; $display("FAIL lvl_n2_id got %0d want 4", irq_id_o); end
    bus_rd(32'h0C, d);
    checks++; if (d !== 32'd4) begin errors++; $display("FAIL lvl_claim got %0d want 4", d); end
    @(negedge clk_i);
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL lvl_irq_drop got %b want 0", irq_o); end
    bus_rd(32'h10, d);
    checks++; if (d !== 32'h0401) begin errors++; $display("FAIL lvl_status got %h want 0401", d); end
    bus_wr(32'h0C, 32'd4);
    @(negedge clk_i);
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL lvl_refire got %b want 1", irq_o); end
    irq_src_i[3] = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL lvl_release got %b want 0", irq_o); end
  endtask

  task automatic test_edge();
    logic [31:0] d;
    do_reset();
    bus_wr(32'h00, 32'h24);
    bus_wr(32'h04, 32'h24);
    @(negedge clk_i);
    irq_src_i = 32'h24;
    @(negedge clk_i);
    irq_src_i = 32'h0;
    repeat (2) @(negedge clk_i);
    checks++; if (irq_id_o !== 6'd3) begin errors++; $display("FAIL edge_id got %0d want 3", irq_id_o); end
    bus_rd(32'h08, d);
    checks++; if (d !== 32'h24) begin errors++; $display("FAIL edge_pend got %h want 24", d); end
    bus_rd(32'h0C, d);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL edge_claim1 got %0d want 3", d); end
    bus_rd(32'h10, d);
    checks++; if (d !== 32'h0301) begin errors++; $display("FAIL edge_status1 got %h want 0301", d); end
    bus_wr(32'h0C, 32'd7);
    bus_rd(32'h10, d);
    checks++; if (d !== 32'h0301) begin errors++; $display("FAIL bad_complete got %h want 0301", d); end
    bus_rd(32'h0C, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL svc_claim got %0d want 0", d); end
    bus_rd(32'h10, d);
    checks++; if (d !== 32'h0301) begin errors++; $display("FAIL svc_claim_state got %h want 0301", d); end
    bus_rd(32'h08, d);
    checks++; if (d !== 32'h20) begin errors++; $display("FAIL edge_pend_mid got %h want 20", d); end
    bus_wr(32'h0C, 32'd3);
    bus_rd(32'h0C, d);
    checks++; if (d !== 32'd6) begin errors++; $display("FAIL edge_claim2 got %0d want 6", d); end
    bus_rd(32'h08, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL edge_pend_end got %h want 0", d); end
    bus_wr(32'h0C, 32'd6);
    bus_wr(32'h0C, 32'd6);
    bus_rd(32'h10, d);
    checks++; if (d[0] !== 1'b0) begin errors++; $display("FAIL idle_complete got %b want 0", d[0]); end
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    do_reset();
    bus_wr(32'h04, 32'h4);
    @(negedge clk_i);
    irq_src_i[2] = 1'b1;
    @(negedge clk_i);
    irq_src_i[2] = 1'b0;
    @(negedge clk_i);
    bus_rd(32'h08, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL w1c_pre got %h want 4", d); end
    bus_wr(32'h08, 32'h4);
    bus_rd(32'h08, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_clear got %h want 0", d); end
    bus_wr(32'h08, 32'h4);
    @(negedge clk_i);
    mem_valid_i  = 1'b1;
    mem_addr_i   = 32'h08;
    mem_wdata_i  = 32'h4;
    mem_wstrb_i  = 4'hF;
    irq_src_i[2] = 1'b1;
    @(negedge clk_i);
    checks++; if (mem_ready_o !== 1'b1) begin errors++; $display("FAIL race_ready got %b want 1", mem_ready_o); end
    mem_valid_i  = 1'b0;
    mem_wstrb_i  = '0;
    irq_src_i[2] = 1'b0;
    bus_rd(32'h08, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL set_wins got %h want 4", d); end
  endtask

  task automatic test_sync();
    logic [31:0] d;
    int n;
    do_reset();
    bus_wr(32'h04, 32'h0003_0000);
    bus_wr(32'h00, 32'h0001_0000);
    irq_src_i[16] = 1'b1;
    n = 0;
    while (!irq_o && n < 10) begin
      @(negedge clk_i);
      n++;
      if (n == 1) irq_src_i[16] = 1'b0;
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL raw_delay got %0d want 2", n); end
    do_reset();
    bus_wr(32'h04, 32'h0003_0000);
    bus_wr(32'h00, 32'h0002_0000);
    irq_src_i[17] = 1'b1;
    n = 0;
    while (!irq_o && n < 10) begin
      @(negedge clk_i);
      n++;
      if (n == 1) irq_src_i[17] = 1'b0;
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL sync_delay got %0d want 4", n); end
    bus_rd(32'h08, d);
    checks++; if (d !== 32'h0002_0000) begin errors++; $display("FAIL glitch_pend got %h want 00020000", d); end
    bus_wr(32'h08, 32'h0002_0000);
    repeat (5) @(negedge clk_i);
    bus_rd(32'h08, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL glitch_once got %h want 0", d); end
  endtask

  task automatic test_strobes();
    logic [31:0] d;
    do_reset();
    bus_xfer(32'h00, 32'hFFFF_FFFF, 4'b0010, d);
    bus_rd(32'h00, d);
    checks++; if (d !== 32'h0000_FF00) begin errors++; $display("FAIL strobe got %h want 0000ff00", d); end
    bus_wr(32'h14, 32'hFFFF_FFFF);
    bus_rd(32'h14, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped got %h want 0", d); end
    bus_wr(32'h10, 32'hFFFF_FFFF);
    bus_rd(32'h10, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL status_ro got %h want 0", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    do_reset();
    bus_wr(32'h00, 32'h8);
    irq_src_i[3] = 1'b1;
    repeat (3) @(negedge clk_i);
    bus_rd(32'h0C, d);
    checks++; if (d !== 32'd4) begin errors++; $display("FAIL mid_claim got %0d want 4", d); end
    @(negedge clk_i);
    mem_valid_i = 1'b1;
    mem_addr_i  = 32'h10;
    mem_wstrb_i = 4'h0;
    rst_i       = 1'b1;
    @(negedge clk_i);
    checks++; if (mem_ready_o !== 1'b0) begin errors++; $display("FAIL mid_ready got %b want 0", mem_ready_o); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL mid_irq got %b want 0", irq_o); end
    checks++; if (mem_rdata_o !== 32'h0) begin errors++; $display("FAIL mid_rdata got %h want 0", mem_rdata_o); end
    rst_i       = 1'b0;
    mem_valid_i = 1'b0;
    irq_src_i   = '0;
    @(negedge clk_i);
    checks++; if (mem_ready_o !== 1'b0) begin errors++; $display("FAIL mid_no_pulse got %b want 0", mem_ready_o); end
    bus_rd(32'h10, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_status got %h want 0", d); end
    bus_rd(32'h00, d);
    checks++; if (d !== 32'h0000_0100) begin errors++; $display("FAIL mid_enable got %h want 00000100", d); end
  endtask

  initial begin
    rst_i       = 1'b1;
    irq_src_i   = '0;
    mem_valid_i = 1'b0;
    mem_addr_i  = '0;
    mem_wdata_i = '0;
    mem_wstrb_i = '0;
    @(negedge clk_i);
    test_reset();
    test_level();
    test_edge();
    test_set_wins();
    test_sync();
    test_strobes();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
